// File: rtl/serial_subtract_ctrl_if.sv
// Handshake and data bundle between an operand source / result consumer
// and the bit-serial subtracter controller.
interface serial_subtract_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;
   logic             busy;

   // Source/consumer side: drives operands and accepts results.
   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, zero, busy
   );

   // Subtracter side.
   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, zero, busy
   );
endinterface

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtracter: one full-subtracter cell walks the operands LSB
// first, producing diff = a - b - bin (mod 2^WIDTH) and the MSB borrow
// after WIDTH cycles. Operand accept and result delivery use valid/ready.
module serial_subtract_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_subtract_ctrl_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   // Only WIDTH-1 partial bits are held; the last bit goes straight to diff.
   logic [WIDTH-2:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             zero_q, zero_d;

   logic             d_bit;
   logic             borrow_nx;
   logic [WIDTH-1:0] full_w;

   // Next-state, datapath shifting and result capture.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      br_d      = br_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      diff_d    = diff_q;
      bout_d    = bout_q;
      zero_d    = zero_q;

      d_bit     = a_q[0] ^ b_q[0] ^ br_q;
      borrow_nx = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
      full_w    = {d_bit, res_q};

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid == 1'b1) begin
               a_d     = bus.a;
               b_d     = bus.b;
               br_d    = bus.bin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = borrow_nx;
            res_d = full_w[WIDTH-1:1];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // Final bit: publish the complete result in the same edge.
               cnt_d   = '0;
               diff_d  = full_w;
               bout_d  = borrow_nx;
               zero_d  = (full_w == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready == 1'b1) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;
   assign bus.zero      = zero_q;

endmodule

// File: doc/serial_subtract_ctrl.md
Name: serial_subtract_ctrl

Overview:
Sequences a 1-bit full subtracter over WIDTH bits, LSB first, so one subtracter cell performs an N-bit subtraction A - B - bin.
- Holds the operand shift registers and the borrow flip-flop, and runs the bit counter and control FSM.
- Has valid/ready handshakes on input and output.
- Sits between an operand source and a result consumer where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
in_valid  input  1  operand set presented.
in_ready  output  1  block can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow-in applied to bit 0.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  A - B - bin modulo 2^WIDTH.
bout  output  1  borrow out of MSB; 1 when unsigned A < B + bin.
zero  output  1  diff == 0.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low at a clock edge):
  - FSM goes to IDLE; bit counter is 0; borrow register is 0; operand and result registers are 0.
  - Outputs: in_ready=1, out_valid=0, diff=0, bout=0, zero=0, busy=0.
  - Reset has priority over every other event, including mid-RUN and mid-DONE. Any partial result is discarded and no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid && in_ready, load a and b into the shift registers, load the borrow register with bin, clear the counter and result register, and go to RUN.
- RUN:
  - in_ready=0, busy=1. One bit is processed per cycle.
  - Difference bit d = a0 ^ b0 ^ br.
  - Next borrow = (~a0 & b0) | (~a0 & br) | (b0 & br).
  - d shifts into the MSB of the result register; the operand registers shift right by 1; the counter increments.
  - When the counter reaches WIDTH-1, the final bit is processed that cycle, then the FSM goes to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - diff, bout and zero are registered and stay stable while out_valid=1 && out_ready=0.
  - On out_ready=1, go to IDLE the next cycle; out_valid drops the same edge.
- Latency:
  - Accept edge at cycle T, out_valid first high in cycle T+WIDTH+1.
  - With out_ready held high, the next accept is possible in cycle T+WIDTH+2.
- Operands and bin presented while in_ready=0 are ignored; no queuing.
- diff, bout and zero keep their last values after leaving DONE until the next result is loaded. Consumers sample them only with out_valid.
- zero is computed from the final result register, not accumulated per bit.
- Width rules:
  - Counter width is clog2(WIDTH).
  - Wrap-around is modulo 2^WIDTH; there is no saturation.
- out_ready asserted outside DONE has no effect.
- X on inputs while in_valid=0 must not propagate into state.

Test Plan:
- WIDTH=8, accept a=0x05 b=0x03 bin=0 with out_ready=1: result is diff=0x02 bout=0 zero=0, out_valid exactly 9 cycles after the accept edge and high for 1 cycle.
- a=0x03 b=0x05 bin=0: result is diff=0xFE bout=1 zero=0. Then a=0x00 b=0x00 bin=1: result is diff=0xFF bout=1 (full borrow ripple).
- a=0xAA b=0xAA bin=0: result is diff=0x00 bout=0 zero=1. Also a=0xFF b=0x00 bin=0: result is diff=0xFF bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1 and diff/bout/zero are stable.
  - in_valid pulses with new operands are ignored, with in_ready=0.
  - Release out_ready: IDLE on the next cycle.
- Reset mid-operation: drive rst_n=0 at RUN bit 3 of a=0x80 b=0x01 for 1 edge.
  - Next cycle: IDLE, in_ready=1, out_valid=0, diff=0, busy=0.
  - No result ever appears for the aborted operation.
- Randomised exhaustive sweep at WIDTH=4: all 512 (a,b,bin) combinations back-to-back with out_ready=1.
  - Each result matches {bout,diff} = {1'b0,a} - b - bin, taken modulo 32.
  - Accept-to-accept spacing is exactly 6 cycles.
